bip_control: RTL and testbench

- Control unit for the BIP processor; it is the instruction-side counterpart of the accumulator datapath.
- Owns the program counter and fetches 16-bit instructions (5-bit opcode, 11-bit operand) from synchronous program memory.
- Decodes each instruction and drives the datapath controls (SEL_A, SEL_B, WR_ACC, OP), the operand and the data-memory strobes.
- Runs a fixed 3-cycle FETCH/DECODE/EXEC sequence per instruction, with a HALT state and a single-step enable for the debug unit.

---
 rtl/bip_control_if.sv | 28 ++
 rtl/bip_control.sv | 88 ++++++++
 tb/tb_bip_control.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/bip_control_if.sv
// bip_control_if: instruction-fetch and datapath-control bundle between the BIP control unit and its datapath/memories
interface bip_control_if #(
    parameter int PC_W  = 11,
    parameter int CNT_W = 16
);
    logic             ENABLE;
    logic [15:0]      PM_DATA;
    logic [PC_W-1:0]  PM_ADDR;
    logic [10:0]      OPERAND;
    logic [1:0]       SEL_A;
    logic             SEL_B;
    logic             OP;
    logic             WR_ACC;
    logic             RD_RAM;
    logic             WR_RAM;
    logic             HALTED;
    logic [CNT_W-1:0] CYCLES;

    modport master (
        input  ENABLE, PM_DATA,
        output PM_ADDR, OPERAND, SEL_A, SEL_B, OP, WR_ACC, RD_RAM, WR_RAM, HALTED, CYCLES
    );

    modport slave (
        output ENABLE, PM_DATA,
        input  PM_ADDR, OPERAND, SEL_A, SEL_B, OP, WR_ACC, RD_RAM, WR_RAM, HALTED, CYCLES
    );
endinterface

// File: rtl/bip_control.sv
// bip_control: BIP control unit - PC, instruction fetch, FETCH/DECODE/EXEC/HALT sequencing and datapath control decode
module bip_control #(
    parameter int PC_W  = 11,
    parameter int CNT_W = 16
) (
    input logic           CLK,
    input logic           RESET,
    bip_control_if.master bus
);
    typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [4:0]       dec_opc, exe_opc;

    assign dec_opc = bus.PM_DATA[15:11];
    assign exe_opc = ir_q[15:11];

    // State, PC, IR and cycle counter registers with asynchronous reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cyc_q   <= cyc_d;
        end
    end

    // Sequencing: ENABLE only gates leaving FETCH; HLT parks in HALT with PC and counter frozen
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cyc_d   = cyc_q;
        case (state_q)
            FETCH: begin
                state_d = bus.ENABLE ? DECODE : FETCH;
                cyc_d   = bus.ENABLE ? cyc_q + 1'b1 : cyc_q;
            end
            DECODE: begin
                ir_d    = bus.PM_DATA;
                state_d = (dec_opc == 5'd0) ? HALT : EXEC;
                cyc_d   = cyc_q + 1'b1;
            end
            EXEC: begin
                pc_d    = pc_q + 1'b1;
                state_d = FETCH;
                cyc_d   = cyc_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath controls: memory read announced in DECODE, all writes confined to the single EXEC cycle
    always_comb begin
        bus.PM_ADDR = pc_q;
        bus.HALTED  = (state_q == HALT);
        bus.CYCLES  = cyc_q;
        bus.OPERAND = (state_q == DECODE) ? bus.PM_DATA[10:0] : ir_q[10:0];
        bus.SEL_A   = 2'd0;
        bus.SEL_B   = 1'b0;
        bus.OP      = 1'b0;
        bus.WR_ACC  = 1'b0;
        bus.RD_RAM  = 1'b0;
        bus.WR_RAM  = 1'b0;
        if (state_q == DECODE)
            bus.RD_RAM = (dec_opc == 5'd2) || (dec_opc == 5'd4) || (dec_opc == 5'd6);
        if (state_q == EXEC) begin
            case (exe_opc)
                5'd1: bus.WR_RAM = 1'b1;
                5'd2: begin bus.WR_ACC = 1'b1; bus.RD_RAM = 1'b1; end
                5'd3: begin bus.SEL_A = 2'd1; bus.WR_ACC = 1'b1; end
                5'd4: begin bus.SEL_A = 2'd2; bus.SEL_B = 1'b1; bus.WR_ACC = 1'b1; bus.RD_RAM = 1'b1; end
                5'd5: begin bus.SEL_A = 2'd2; bus.WR_ACC = 1'b1; end
                5'd6: begin bus.SEL_A = 2'd2; bus.SEL_B = 1'b1; bus.OP = 1'b1; bus.WR_ACC = 1'b1; bus.RD_RAM = 1'b1; end
                5'd7: begin bus.SEL_A = 2'd2; bus.OP = 1'b1; bus.WR_ACC = 1'b1; end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: randomized and directed check of bip_control against an instruction-level reference model
module tb_bip_control;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   strobes = 0;
    bit   started = 1'b0;

    logic [15:0] mem [2048];

    int          m_st;
    int          m_pc;
    int          m_cyc;
    logic [15:0] m_ir;

    logic [6:0] ctab [8] = '{7'b0000000, 7'b0000010, 7'b0000101, 7'b0100100,
                             7'b1010101, 7'b1000100, 7'b1011101, 7'b1001100};

    bip_control_if #(.PC_W(11), .CNT_W(16)) bus ();

    bip_control #(.PC_W(11), .CNT_W(16)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.master)
    );

    always #5 CLK = ~CLK;

    // Synchronous program memory: data for an address appears the cycle after it is presented
    always @(posedge CLK) bus.PM_DATA <= mem[bus.PM_ADDR];

    function automatic logic [15:0] ins(input int o, input int a);
        return 16'(((o & 31) << 11) | (a & 2047));
    endfunction

    function automatic logic [6:0] ctl(input logic [4:0] o);
        return (o < 5'd8) ? ctab[o[2:0]] : 7'd0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one instruction = fetch step, decode step, execute step; HLT parks the machine
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_st  <= 0;
            m_pc  <= 0;
            m_cyc <= 0;
            m_ir  <= 16'd0;
        end else begin
            if (m_st == 1 || m_st == 2 || (m_st == 0 && bus.ENABLE)) m_cyc <= (m_cyc + 1) % 65536;
            if (m_st == 0 && bus.ENABLE) m_st <= 1;
            else if (m_st == 1) begin
                m_ir <= mem[m_pc];
                m_st <= (mem[m_pc][15:11] == 5'd0) ? 3 : 2;
            end else if (m_st == 2) begin
                m_pc <= (m_pc + 1) % 2048;
                m_st <= 0;
            end
        end
    end

    // Every cycle: compare all DUT outputs against the model's expectation
    always @(negedge CLK) begin
        logic [6:0]  c;
        logic [10:0] oe;
        logic [63:0] exp, act;
        c  = 7'd0;
        oe = 11'd0;
        if (m_st == 1) begin
            c  = {6'd0, ctl(mem[m_pc][15:11])[0]};
            oe = mem[m_pc][10:0];
        end else if (m_st == 2) begin
            c  = ctl(m_ir[15:11]);
            oe = m_ir[10:0];
        end
        exp = {18'd0, 11'(m_pc), oe, c[6:5], c[4], c[3], c[2], c[0], c[1], 1'(m_st == 3), 16'(m_cyc)};
        act = {18'd0, bus.PM_ADDR, (m_st == 1 || m_st == 2) ? bus.OPERAND : 11'd0, bus.SEL_A, bus.SEL_B,
               bus.OP, bus.WR_ACC, bus.RD_RAM, bus.WR_RAM, bus.HALTED, bus.CYCLES};
        if (started) begin
            chk("cycle", act, exp);
            if (bus.WR_ACC || bus.WR_RAM || bus.RD_RAM) strobes++;
        end
    end

    task automatic prep();
        #3 RESET = 1'b1;
        for (int i = 0; i < 2048; i++) mem[i] = ins(31, 0);
    endtask

    task automatic start(input logic en);
        bus.ENABLE = en;
        repeat (2) @(negedge CLK);
        RESET   = 1'b0;
        started = 1'b1;
    endtask

    initial begin
        int s0;
        bus.ENABLE = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = ins(31, 0);
        repeat (2) @(negedge CLK);

        // Reset state, ENABLE hold, single-step pulse
        prep();
        mem[0] = ins(3, 5);
        mem[1] = ins(3, 6);
        start(1'b0);
        chk("rst_pc", bus.PM_ADDR, 0);
        chk("rst_cyc", bus.CYCLES, 0);
        chk("rst_halt", bus.HALTED, 0);
        repeat (4) @(negedge CLK);
        chk("hold_pc", bus.PM_ADDR, 0);
        chk("hold_cyc", bus.CYCLES, 0);
        chk("hold_strobe", {bus.WR_ACC, bus.WR_RAM, bus.RD_RAM}, 0);
        bus.ENABLE = 1'b1;
        @(negedge CLK);
        bus.ENABLE = 1'b0;
        repeat (5) @(negedge CLK);
        chk("step_pc", bus.PM_ADDR, 1);
        chk("step_cyc", bus.CYCLES, 3);

        // LDI 5, ADDI 3, STO 0x010, HLT
        prep();
        mem[0] = ins(3, 5);
        mem[1] = ins(5, 3);
        mem[2] = ins(1, 16);
        mem[3] = ins(0, 0);
        start(1'b1);
        for (int k = 1; k <= 14; k++) begin
            @(negedge CLK);
            if (k == 2) chk("ldi_ctl", {bus.WR_ACC, bus.SEL_A, bus.OPERAND}, {1'b1, 2'd1, 11'd5});
            if (k == 5) chk("addi_ctl", {bus.WR_ACC, bus.SEL_A, bus.SEL_B, bus.OP}, 5'b11000);
            if (k == 8) chk("sto_ctl", {bus.WR_RAM, bus.WR_ACC, bus.OPERAND}, {2'b10, 11'h010});
        end
        chk("prog_halt", bus.HALTED, 1);
        chk("prog_pc", bus.PM_ADDR, 3);
        chk("prog_cyc", bus.CYCLES, 11);

        // LD 0x005, SUB 0x006
        prep();
        mem[0] = ins(2, 5);
        mem[1] = ins(6, 6);
        mem[2] = ins(0, 0);
        start(1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            if (k == 1) chk("ld_dec_rd", bus.RD_RAM, 1);
            if (k == 2) chk("ld_exec", {bus.RD_RAM, bus.WR_ACC, bus.SEL_A}, 4'b1100);
            if (k == 4) chk("sub_dec_rd", bus.RD_RAM, 1);
            if (k == 5) chk("sub_exec", {bus.RD_RAM, bus.WR_ACC, bus.SEL_A, bus.SEL_B, bus.OP, bus.OPERAND},
                            {1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 11'h006});
        end

        // HLT at PC 0: absorbing regardless of ENABLE
        prep();
        mem[0] = ins(0, 0);
        start(1'b1);
        repeat (2) @(negedge CLK);
        chk("hlt_halted", bus.HALTED, 1);
        for (int i = 0; i < 20; i++) begin
            bus.ENABLE = 1'($urandom);
            @(negedge CLK);
        end
        chk("hlt_cyc", bus.CYCLES, 2);
        chk("hlt_pc", bus.PM_ADDR, 0);
        chk("hlt_still", bus.HALTED, 1);

        // Reset during EXEC of ADDI at PC 1
        prep();
        mem[1] = ins(5, 3);
        start(1'b1);
        repeat (5) @(negedge CLK);
        chk("addi_wr", bus.WR_ACC, 1);
        #2 RESET = 1'b1;
        #1 chk("arst_wr", bus.WR_ACC, 0);
        chk("arst_pc", bus.PM_ADDR, 0);
        chk("arst_cyc", bus.CYCLES, 0);
        bus.ENABLE = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        chk("arst_fetch", {bus.HALTED, bus.PM_ADDR, bus.CYCLES}, 0);

        // 2048 NOPs: PC wraps, nothing strobed
        prep();
        for (int i = 0; i < 2048; i++) mem[i] = ins($urandom_range(8, 31), $urandom);
        start(1'b1);
        s0 = strobes;
        repeat (3 * 2047) @(negedge CLK);
        chk("nop_pc_top", bus.PM_ADDR, 2047);
        repeat (3) @(negedge CLK);
        chk("nop_pc_wrap", bus.PM_ADDR, 0);
        chk("nop_strobes", strobes - s0, 0);
        chk("nop_cyc", bus.CYCLES, 6144);

        // Random programs, random ENABLE, occasional mid-run reset
        for (int r = 0; r < 4; r++) begin
            prep();
            for (int i = 0; i < 2048; i++)
                mem[i] = ins(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 7), $urandom);
            start(1'b1);
            for (int c = 0; c < 400; c++) begin
                bus.ENABLE = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 150) == 0) begin
                    #3 RESET = 1'b1;
                    @(negedge CLK);
                    RESET = 1'b0;
                end else @(negedge CLK);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
